park_exit: RTL and testbench
============================

Name: park_exit

Overview:
Exit-side gate controller for the parking lot, the counterpart of the entry gate.
- Tracks which vehicle IDs are inside and when each entered, using entry events from the entry gate's barrier-open pulse.
- At exit it computes a duration-based fee, accepts coins, and opens the exit barrier once the fee is covered.
- Counts occupancy and flags vehicles that try to exit without having entered.

Parameters:
TW, 16, width of free-running time counter and entry timestamps
UNIT_SHIFT, 4, fee unit = 2^UNIT_SHIFT cycles
FEE_MAX, 200, fee saturation value (fits 8 bits)
PAY_TIMEOUT, 20, cycles allowed in PAY before abort
HOLD, 2, cycles BS_exit stays high

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
ent_valid  in  1  entry event (entry barrier opened this cycle)
ent_id  in  3  ID of entering vehicle; 0 = none
veh  in  3  ID at exit reader; 0 = no vehicle
coin  in  2  00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
BS_exit  out  1  exit barrier open
fee  out  8  fee of current exiting vehicle
paid  out  8  amount inserted so far
change  out  8  change or refund amount
error  out  1  one-cycle pulse on payment timeout
not_in  out  1  one-cycle pulse when unknown ID presented
occupancy  out  3  number of vehicles inside (0..7)
full  out  1  occupancy == 7

Behaviour:
Reset:
- Reset is synchronous and active-high.
- All outputs return to 0.
- inside[7:1] is cleared, timer is 0, state is IDLE.
- Reset mid-operation aborts any transaction; the barrier closes on the next edge.

Time base:
- now is a TW-bit free-running counter that wraps.
- Elapsed = now − stamp, taken modulo 2^TW. It is correct for stays shorter than 2^TW cycles.

Entry tracking:
- Entry is recorded when ent_valid=1, ent_id≠0 and inside[ent_id]=0.
- On record: inside[ent_id] <= 1 and stamp[ent_id] <= now at that edge.
- Entry for an ID already inside is ignored. This includes the cycle in which exit clears that ID.
- Entry processing is independent of the FSM state.

occupancy / full:
- occupancy is a registered popcount of inside, updated the cycle after the change.
- full is a registered compare, occupancy == 7.

FSM:
- IDLE:
  - Samples veh.
  - veh≠0 and inside[veh]=1: latch id, go to CALC.
  - veh≠0 and inside[veh]=0: pulse not_in for one cycle, stay IDLE.
  - veh=0: stay IDLE.
- CALC (1 cycle):
  - fee <= min((now − stamp[id]) >> UNIT_SHIFT, FEE_MAX−1) + 1, so the minimum fee is 1.
  - paid <= 0, change <= 0, pay timer <= 0.
  - Go to PAY.
- PAY:
  - Each cycle with coin≠0: sum = paid + value, saturating at 255.
  - If sum ≥ fee: change <= sum − fee, inside[id] <= 0, go to OPEN.
  - Otherwise paid <= sum.
  - The timer increments every PAY cycle and is not reset by coins.
  - If timer == PAY_TIMEOUT−1 and this cycle did not complete payment: error pulses for one cycle, change <= paid (refund), go to IDLE. The vehicle remains inside.
  - A completing coin in the timeout cycle wins over the timeout.
- OPEN:
  - BS_exit=1 for exactly HOLD cycles, then 0, then go to IDLE.
  - veh is ignored in OPEN and PAY.

Output holding:
- fee, paid and change hold their values until the next CALC.

Latency:
- Valid veh to fee valid is 2 edges.
- Completing coin to BS_exit=1 is 1 edge.

Decomposition:
- park_pkg holds:
  - state enum (IDLE, CALC, PAY, OPEN)
  - coin encodings and the coin-value function
  - ID width constant (3) and NO_VEH = 0
- One sub-module, park_fee_calc: combinational elapsed/shift/saturate/+1 computation. It is instantiated once and keeps the FSM file clean.
- Timestamp array and inside bits stay in park_exit.

Test Plan:
- Normal exit (UNIT_SHIFT=4): ent_id=1 at time T, veh=1 so CALC sees elapsed 40 → fee=3. Coins 10, 10 → paid 2, then 4 ≥ 3 → change=1, BS_exit high 2 cycles, occupancy 1→0.
- Unknown vehicle: veh=3 with nothing inside → not_in pulses once, state IDLE, fee unchanged, BS_exit=0.
- Timeout: enter ID 2, exit immediately → fee=1. No coins for 20 PAY cycles → error pulse, change=0, inside[2] still 1, occupancy=1.
- Partial pay then timeout: fee=5, coin 01 then 01 → paid=2. Timeout → error, change=2. Re-presenting veh=2 recomputes a larger-or-equal fee.
- Occupancy/full/duplicates: enter IDs 1..7 → occupancy 7, full=1. Repeat ent_id=4 → no change, stamp[4] kept. Simultaneous ent_valid ent_id=5 during ID 5's completing coin → ID 5 ends outside.
- Reset mid-PAY: reset during PAY with paid=3 → next edge all outputs 0, occupancy 0. A subsequent veh of a previously-inside ID produces a not_in pulse.

Source files
------------

// File: rtl/park_pkg.sv
// park_pkg: types and constants shared by the parking-lot exit gate.
//   state_t     : exit FSM states (IDLE, CALC, PAY, OPEN)
//   COIN_*      : coin input encodings, coin_value() maps a code to units
//   ID_W/NO_VEH : vehicle ID width and the "no vehicle" ID
//   pop7()      : population count of the seven inside bits
package park_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_PAY  = 2'd2,
    S_OPEN = 2'd3
  } state_t;

  localparam int ID_W = 3;
  localparam logic [ID_W-1:0] NO_VEH = '0;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  function automatic logic [7:0] coin_value(input logic [1:0] c);
    logic [7:0] v;
    case (c)
      COIN_1:  v = 8'd1;
      COIN_2:  v = 8'd2;
      COIN_5:  v = 8'd5;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] pop7(input logic [7:1] v);
    logic [2:0] n;
    n = '0;
    for (int i = 1; i <= 7; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/park_fee_calc.sv
// park_fee_calc: combinational exit fee from the stay duration.
//   i_now   : free-running time counter
//   i_stamp : entry timestamp of the exiting vehicle
//   o_fee   : min((i_now - i_stamp) >> UNIT_SHIFT, FEE_MAX-1) + 1
// The subtraction wraps modulo 2^TW, so stays shorter than 2^TW cycles
// are measured correctly even across a counter wrap.
module park_fee_calc #(
  parameter int TW         = 16,
  parameter int UNIT_SHIFT = 4,
  parameter int FEE_MAX    = 200
) (
  input  logic [TW-1:0] i_now,
  input  logic [TW-1:0] i_stamp,
  output logic [7:0]    o_fee
);

  localparam logic [TW-1:0] CAP_W = TW'(FEE_MAX - 1);
  localparam logic [7:0]    CAP_8 = 8'(FEE_MAX - 1);

  logic [TW-1:0] w_elapsed;
  logic [TW-1:0] w_units;
  logic [7:0]    w_fee_m1;

  assign w_elapsed = i_now - i_stamp;
  assign w_units   = w_elapsed >> UNIT_SHIFT;
  // Saturate before the +1 so the minimum fee is 1 and the maximum FEE_MAX.
  assign w_fee_m1  = (w_units > CAP_W) ? CAP_8 : w_units[7:0];
  assign o_fee     = w_fee_m1 + 8'd1;

endmodule

// File: rtl/park_exit.sv
// park_exit: exit-side gate controller of the parking lot.
//   clk, reset : clock, synchronous active-high reset
//   ent_valid  : entry barrier opened this cycle, ent_id = entering vehicle
//   veh        : ID at the exit reader (0 = none)
//   coin       : 00 none, 01 = 1, 10 = 2, 11 = 5 units
//   BS_exit    : exit barrier open (HOLD cycles)
//   fee/paid/change : current transaction amounts, held until next CALC
//   error      : one-cycle pulse on payment timeout (paid amount refunded)
//   not_in     : one-cycle pulse when an ID not inside is presented
//   occupancy/full : registered vehicle count and count == 7
module park_exit
  import park_pkg::*;
#(
  parameter int TW          = 16,
  parameter int UNIT_SHIFT  = 4,
  parameter int FEE_MAX     = 200,
  parameter int PAY_TIMEOUT = 20,
  parameter int HOLD        = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ent_valid,
  input  logic [ID_W-1:0] ent_id,
  input  logic [ID_W-1:0] veh,
  input  logic [1:0]      coin,
  output logic            BS_exit,
  output logic [7:0]      fee,
  output logic [7:0]      paid,
  output logic [7:0]      change,
  output logic            error,
  output logic            not_in,
  output logic [2:0]      occupancy,
  output logic            full
);

  localparam int TMR_W  = $clog2(PAY_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(HOLD + 1);

  // time base and per-ID entry bookkeeping (bit/entry 0 unused: NO_VEH)
  logic [TW-1:0]    r_now;
  logic [7:0]       r_inside;
  logic [TW-1:0]    r_stamp [0:7];

  // FSM and transaction registers
  state_t           r_state;
  logic [ID_W-1:0]  r_id;
  logic [TMR_W-1:0] r_timer;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]       r_fee;
  logic [7:0]       r_paid;
  logic [7:0]       r_change;
  logic             r_bs;
  logic             r_err;
  logic             r_notin;
  logic [2:0]       r_occ;
  logic             r_full;

  logic             w_ent_rec;
  logic [7:0]       w_coin_val;
  logic [8:0]       w_sum9;
  logic [7:0]       w_sum;
  logic             w_pay_done;
  logic             w_timeout;
  logic [7:0]       w_fee;
  logic [2:0]       w_pop;

  // An ID already inside is never re-stamped; this also covers the cycle
  // in which its exit clears it, because r_inside is still set then.
  assign w_ent_rec  = ent_valid && (ent_id != NO_VEH) && !r_inside[ent_id];

  assign w_coin_val = coin_value(coin);
  assign w_sum9     = {1'b0, r_paid} + {1'b0, w_coin_val};
  assign w_sum      = w_sum9[8] ? 8'hFF : w_sum9[7:0];

  // A completing coin beats the timeout in the same cycle.
  assign w_pay_done = (r_state == S_PAY) && (coin != COIN_NONE) && (w_sum >= r_fee);
  assign w_timeout  = (r_state == S_PAY) && (r_timer == TMR_W'(PAY_TIMEOUT - 1)) && !w_pay_done;

  assign w_pop      = pop7(r_inside[7:1]);

  park_fee_calc #(
    .TW        (TW),
    .UNIT_SHIFT(UNIT_SHIFT),
    .FEE_MAX   (FEE_MAX)
  ) u_fee (
    .i_now  (r_now),
    .i_stamp(r_stamp[r_id]),
    .o_fee  (w_fee)
  );

  always_ff @(posedge clk) begin
    if (reset) r_now <= '0;
    else       r_now <= r_now + 1'b1;
  end

  // Timestamps need no reset: they are only read for IDs marked inside.
  always_ff @(posedge clk) begin
    if (w_ent_rec) r_stamp[ent_id] <= r_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inside <= '0;
    end else begin
      if (w_ent_rec)  r_inside[ent_id] <= 1'b1;
      if (w_pay_done) r_inside[r_id]   <= 1'b0;
    end
  end

  // occupancy and full are registered together from the same popcount so
  // full always agrees with the occupancy value being presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ  <= '0;
      r_full <= 1'b0;
    end else begin
      r_occ  <= w_pop;
      r_full <= (w_pop == 3'd7);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_id     <= NO_VEH;
      r_timer  <= '0;
      r_hold   <= '0;
      r_fee    <= '0;
      r_paid   <= '0;
      r_change <= '0;
      r_bs     <= 1'b0;
      r_err    <= 1'b0;
      r_notin  <= 1'b0;
    end else begin
      r_err   <= 1'b0;
      r_notin <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (veh != NO_VEH) begin
            if (r_inside[veh]) begin
              r_id    <= veh;
              r_state <= S_CALC;
            end else begin
              r_notin <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_fee    <= w_fee;
          r_paid   <= '0;
          r_change <= '0;
          r_timer  <= '0;
          r_state  <= S_PAY;
        end
        S_PAY: begin
          r_timer <= r_timer + 1'b1;
          if (w_pay_done) begin
            r_change <= w_sum - r_fee;
            r_bs     <= 1'b1;
            r_hold   <= '0;
            r_state  <= S_OPEN;
          end else if (w_timeout) begin
            // vehicle stays inside; everything inserted is refunded
            r_err    <= 1'b1;
            r_change <= r_paid;
            r_state  <= S_IDLE;
          end else if (coin != COIN_NONE) begin
            r_paid <= w_sum;
          end
        end
        S_OPEN: begin
          if (r_hold == HOLD_W'(HOLD - 1)) begin
            r_bs    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BS_exit   = r_bs;
  assign fee       = r_fee;
  assign paid      = r_paid;
  assign change    = r_change;
  assign error     = r_err;
  assign not_in    = r_notin;
  assign occupancy = r_occ;
  assign full      = r_full;

endmodule

// File: tb/tb_park_exit.sv
module tb_park_exit;

  logic       clk, reset, ent_valid;
  logic [2:0] ent_id, veh;
  logic [1:0] coin;
  logic       BS_exit, error, not_in, full;
  logic [7:0] fee, paid, change;
  logic [2:0] occupancy;

  park_exit dut (
    .clk(clk), .reset(reset), .ent_valid(ent_valid), .ent_id(ent_id),
    .veh(veh), .coin(coin), .BS_exit(BS_exit), .fee(fee), .paid(paid),
    .change(change), .error(error), .not_in(not_in),
    .occupancy(occupancy), .full(full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // expected end-of-transaction outcome: barrier opening or timeout
  typedef struct {
    bit   err;
    int   fee;
    int   change;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int id; int stay; int c0; int c1; int c2;
    int fee; int paid1; int done; int change;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input int act, input int expv);
    n_tot++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mfee(input int el);
    int q;
    q = el >> 4;
    if (q > 199) q = 199;
    return q + 1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // enter id, then present it so CALC sees elapsed == stay (stay >= 2)
  task automatic enter_and_calc(input int id, input int stay);
    ent_valid = 1'b1; ent_id = 3'(id);
    tick();
    ent_valid = 1'b0; ent_id = '0;
    repeat (stay - 2) tick();
    veh = 3'(id);
    tick();
    veh = '0;
    tick();
  endtask

  // pay with 5-unit coins; optionally re-enter ent_id on the completing coin
  task automatic pay_exact(input int f, input int dup_id);
    int n;
    n = (f + 4) / 5;
    sb.push_back('{0, f, 5 * n - f});
    for (int k = 0; k < n; k++) begin
      coin = 2'b11;
      if (k == n - 1 && dup_id != 0) begin
        ent_valid = 1'b1; ent_id = 3'(dup_id);
      end
      tick();
    end
    coin = '0; ent_valid = 1'b0; ent_id = '0;
  endtask

  // scoreboard monitor: pops on barrier rise or timeout pulse, and checks
  // the barrier stays open for exactly two cycles
  initial begin
    exp_t e;
    bit   bs_q;
    int   bs_len;
    bs_q = 1'b0; bs_len = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if ((BS_exit && !bs_q) || error) begin
          if (sb.size() == 0) begin
            chk("sb_unexpected_event", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("sb_error", int'(error), int'(e.err));
            chk("sb_fee", int'(fee), e.fee);
            chk("sb_change", int'(change), e.change);
          end
        end
        if (BS_exit) bs_len++;
        else if (bs_q) begin
          chk("bs_hold_len", bs_len, 2);
          bs_len = 0;
        end
      end
      bs_q = BS_exit;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e4, e5, f4, f5, e2, f2;
    reset = 1'b1; ent_valid = 1'b0; ent_id = '0; veh = '0; coin = '0;
    vt[0] = '{1,   40, 2, 2, 0,   3,  2, 1,  1};
    vt[1] = '{2,    2, 0, 0, 0,   1, -1, 0,  0};
    vt[2] = '{3,   64, 3, 0, 0,   5, -1, 1,  0};
    vt[3] = '{4,   79, 1, 1, 0,   5,  1, 0,  2};
    vt[4] = '{5,   15, 3, 0, 0,   1, -1, 1,  4};
    vt[5] = '{6,   16, 2, 0, 0,   2, -1, 1,  0};
    vt[6] = '{7, 4000, 3, 3, 3, 200,  5, 0, 15};
    vt[7] = '{1, 3183, 2, 0, 0, 199,  2, 0,  2};
    vt[8] = '{2, 3184, 0, 0, 0, 200, -1, 0,  0};
    vt[9] = '{3,   47, 1, 1, 1,   3,  1, 1,  0};
    repeat (2) tick();

    // reset state
    chk("rst_bs", int'(BS_exit), 0);
    chk("rst_fee", int'(fee), 0);
    chk("rst_paid", int'(paid), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_occ", int'(occupancy), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_err_notin", int'({error, not_in}), 0);
    reset = 1'b0;

    // table-driven exits
    foreach (vt[i]) begin
      int cs[3];
      bit first;
      cs[0] = vt[i].c0; cs[1] = vt[i].c1; cs[2] = vt[i].c2;
      do_reset();
      enter_and_calc(vt[i].id, vt[i].stay);
      chk($sformatf("v%0d_fee", i), int'(fee), vt[i].fee);
      chk($sformatf("v%0d_occ_in", i), int'(occupancy), 1);
      sb.push_back('{vt[i].done == 0, vt[i].fee, vt[i].change});
      first = 1'b1;
      for (int j = 0; j < 3; j++) begin
        if (cs[j] != 0) begin
          coin = 2'(cs[j]);
          tick();
          coin = '0;
          if (first && vt[i].paid1 >= 0)
            chk($sformatf("v%0d_paid1", i), int'(paid), vt[i].paid1);
          first = 1'b0;
        end
      end
      if (vt[i].done != 0) chk($sformatf("v%0d_bs_latency", i), int'(BS_exit), 1);
      repeat (25) tick();
      chk($sformatf("v%0d_occ_out", i), int'(occupancy), vt[i].done != 0 ? 0 : 1);
    end

    // unknown vehicle: fee keeps last value, barrier stays shut
    veh = 3'd3;
    tick();
    veh = '0;
    chk("unk_not_in", int'(not_in), 1);
    chk("unk_fee_held", int'(fee), vt[9].fee);
    chk("unk_bs", int'(BS_exit), 0);
    tick();
    chk("unk_not_in_pulse", int'(not_in), 0);

    // partial pay, timeout, then re-present recomputes the fee
    do_reset();
    e2 = cyc + 1;
    enter_and_calc(2, 79);
    chk("rp_fee1", int'(fee), 5);
    sb.push_back('{1, 5, 2});
    coin = 2'b01; tick(); tick(); coin = '0;
    chk("rp_paid", int'(paid), 2);
    repeat (25) tick();
    chk("rp_occ", int'(occupancy), 1);
    veh = 3'd2; tick(); veh = '0; tick();
    f2 = mfee(cyc - e2);
    chk("rp_fee2", int'(fee), f2);

    // occupancy, full, duplicate entry, entry on completing coin
    do_reset();
    e4 = 0; e5 = 0;
    for (int i = 1; i <= 7; i++) begin
      ent_valid = 1'b1; ent_id = 3'(i);
      tick();
      if (i == 4) e4 = cyc;
      if (i == 5) e5 = cyc;
    end
    ent_valid = 1'b0; ent_id = '0;
    repeat (3) tick();
    chk("occ_7", int'(occupancy), 7);
    chk("full_1", int'(full), 1);
    repeat (37) tick();
    ent_valid = 1'b1; ent_id = 3'd4; tick(); ent_valid = 1'b0; ent_id = '0;
    repeat (3) tick();
    chk("dup_occ", int'(occupancy), 7);
    veh = 3'd4; tick(); veh = '0; tick();
    f4 = mfee(cyc - e4);
    chk("dup_stamp_fee", int'(fee), f4);
    pay_exact(f4, 0);
    repeat (5) tick();
    veh = 3'd5; tick(); veh = '0; tick();
    f5 = mfee(cyc - e5);
    chk("id5_fee", int'(fee), f5);
    pay_exact(f5, 5);
    repeat (5) tick();
    chk("occ_5", int'(occupancy), 5);
    chk("full_0", int'(full), 0);
    veh = 3'd5; tick(); veh = '0;
    chk("id5_outside", int'(not_in), 1);

    // reset in the middle of PAY
    do_reset();
    enter_and_calc(2, 100);
    chk("mr_fee", int'(fee), 7);
    coin = 2'b10; tick(); coin = 2'b01; tick(); coin = '0;
    chk("mr_paid", int'(paid), 3);
    reset = 1'b1;
    tick();
    chk("mr_all_zero", int'({BS_exit, fee, paid, change, error, not_in, full}), 0);
    chk("mr_occ", int'(occupancy), 0);
    reset = 1'b0;
    veh = 3'd2; tick(); veh = '0;
    chk("mr_not_in", int'(not_in), 1);
    repeat (3) tick();

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
